// File: rtl/cmd_mode_parser.sv
// In-band command parser: separates rate/channel control sessions from payload bytes.
// Rate codes are edited in a shadow copy and reach o_rate only on an explicit commit.
module cmd_mode_parser #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int RATE_W  = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  logic [7:0]               i_data,
   output logic                     i_ready,
   output logic                     o_valid,
   output logic [7:0]               o_data,
   input  logic                     o_ready,
   output logic [NUM_CH*RATE_W-1:0] o_rate,
   output logic [CH_W-1:0]          o_ch_sel,
   output logic                     o_ctrl_active,
   output logic                     o_clean,
   output logic                     o_finish,
   output logic                     o_err
);

   localparam int             RW       = NUM_CH * RATE_W;
   localparam int             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [3:0]     RATE_LIM = 4'(1 << RATE_W);
   localparam logic [3:0]     CH_LIM   = 4'(NUM_CH);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CTRL  = 2'd2,
      ST_CHSEL = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    rate_q, rate_d;
   logic [RW-1:0]    shadow_q, shadow_d;
   logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             valid_q, valid_d;
   logic [7:0]       data_q, data_d;
   logic             clean_q, clean_d;
   logic             finish_q, finish_d;
   logic             err_q, err_d;

   logic             accept;
   logic             is_digit;
   logic [3:0]       digit_v;
   logic [7:0]       byte_up;

   // Both directions are valid/ready: a byte moves on a cycle where valid && ready,
   // and a producer holds valid and data stable until that cycle.
   assign i_ready  = !reset && (state_q != ST_DATA);
   assign accept   = i_valid && i_ready;
   assign is_digit = (i_data >= 8'h30) && (i_data <= 8'h39);
   assign digit_v  = i_data[3:0];
   // Clearing bit 5 folds lower-case command letters onto upper case.
   assign byte_up  = i_data & 8'hDF;

   always_comb begin
      state_d  = state_q;
      rate_d   = rate_q;
      shadow_d = shadow_q;
      ch_sel_d = ch_sel_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      data_d   = data_q;
      clean_d  = 1'b0;
      finish_d = 1'b0;
      err_d    = 1'b0;
      cnt_inc  = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept) begin
               if (byte_up == 8'h4D) begin
                  state_d  = ST_CTRL;
                  shadow_d = rate_q;
                  ch_sel_d = '0;
               end else if (byte_up == 8'h43) begin
                  rate_d   = '0;
                  shadow_d = '0;
                  ch_sel_d = '0;
                  clean_d  = 1'b1;
               end else if (i_data != 8'h00 && byte_up != 8'h46) begin
                  data_d  = i_data;
                  valid_d = 1'b1;
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            cnt_d = '0;
            if (valid_q && o_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end

         ST_CTRL, ST_CHSEL: begin
            if (accept) begin
               cnt_d = '0;
               if (state_q == ST_CHSEL) begin
                  state_d = ST_CTRL;
                  if (is_digit && digit_v < CH_LIM) begin
                     ch_sel_d = CH_W'(digit_v);
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (is_digit) begin
                  if (digit_v < RATE_LIM) begin
                     for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_sel_q == CH_W'(k)) begin
                           shadow_d[k*RATE_W +: RATE_W] = digit_v[RATE_W-1:0];
                        end
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (byte_up == 8'h4B) begin
                  state_d = ST_CHSEL;
               end else if (byte_up == 8'h46) begin
                  rate_d   = shadow_q;
                  finish_d = 1'b1;
                  state_d  = ST_IDLE;
               end else if (byte_up == 8'h43) begin
                  state_d = ST_IDLE;
               end else if (byte_up == 8'h4D) begin
                  shadow_d = rate_q;
                  ch_sel_d = '0;
               end else if (i_data != 8'h00) begin
                  err_d = 1'b1;
               end
            end else if (TIMEOUT > 0) begin
               // An accepted byte on the expiry cycle takes the branch above instead.
               if (cnt_inc == TO_VAL) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rate_q   <= '0;
         shadow_q <= '0;
         ch_sel_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         data_q   <= 8'h00;
         clean_q  <= 1'b0;
         finish_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rate_q   <= rate_d;
         shadow_q <= shadow_d;
         ch_sel_q <= ch_sel_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         clean_q  <= clean_d;
         finish_q <= finish_d;
         err_q    <= err_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_data        = data_q;
   assign o_rate        = rate_q;
   assign o_ch_sel      = ch_sel_q;
   assign o_ctrl_active = (state_q == ST_CTRL) || (state_q == ST_CHSEL);
   assign o_clean       = clean_q;
   assign o_finish      = finish_q;
   assign o_err         = err_q;

endmodule
